// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring shift-subtract divider for DIV/DIVU.
// Produces {remainder, quotient} after WIDTH+1 cycles in the ON state; divide-by-zero
// returns zero. Optional macro DIV_EARLY_OUT_EN finishes at once when |dividend| < |divisor|.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CntMax = CW'(WIDTH);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] work;      // {partial remainder (W+1), dividend/quotient (W)}
    logic [WIDTH-1:0] divisor;
    logic             neg_quot;
    logic             neg_rem;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;

    // Operand magnitudes, one iteration's trial subtraction and the sign-corrected result.
    always_comb begin
        dividend_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        divisor_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted      = work << 1;
        trial        = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
        quot_fin     = neg_quot ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        rem_fin      = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    end

    // Divider FSM with registered result and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            unique case (state)
                StFree: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= StByZero;
`ifdef DIV_EARLY_OUT_EN
                        end else if (dividend_mag < divisor_mag) begin
                            // Quotient is zero, remainder is the dividend unchanged.
                            state    <= StEnd;
                            ready_o  <= 1'b1;
                            result_o <= {opdata1_i, {WIDTH{1'b0}}};
`endif
                        end else begin
                            state    <= StOn;
                            cnt      <= '0;
                            work     <= {{(WIDTH + 1){1'b0}}, dividend_mag};
                            divisor  <= divisor_mag;
                            neg_quot <= signed_div_i &&
                                        (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem  <= signed_div_i && opdata1_i[WIDTH-1];
                        end
                    end
                end
                StByZero: begin
                    state    <= StEnd;
                    ready_o  <= 1'b1;
                    result_o <= '0;
                end
                StOn: begin
                    if (annul_i) begin
                        state    <= StFree;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt != CntMax) begin
                        // Restoring step: keep the subtraction only if it did not borrow.
                        if (trial[WIDTH]) begin
                            work <= shifted;
                        end else begin
                            work <= {trial, shifted[WIDTH-1:1], 1'b1};
                        end
                        cnt <= cnt + 1'b1;
                    end else begin
                        result_o <= {rem_fin, quot_fin};
                        ready_o  <= 1'b1;
                        state    <= StEnd;
                    end
                end
                StEnd: begin
                    if (!start_i) begin
                        state    <= StFree;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= StFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic model.
module tb_div_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .signed_div_i(sgn),
        .opdata1_i(a),
        .opdata2_i(b),
        .start_i(start),
        .annul_i(annul),
        .result_o(result),
        .ready_o(ready)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Truncating division by plain 64-bit arithmetic; zero divisor yields zero.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint sx, sy, q, r;
        if (y == 32'd0) return 64'd0;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Edges after the start edge until ready is visible.
    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y, input logic s);
        if (y == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mag(x, s) < mag(y, s)) return 0;
`endif
        return W + 1;
    endfunction

    // Timing model: idle / busy (countdown) / done.
    int          m_phase = 0;
    int          m_wait = 0;
    logic        m_ready = 1'b0;
    logic [63:0] m_result = '0;
    logic [63:0] m_exp = '0;
    logic        m_abortable = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            m_ready  <= 1'b0;
            m_result <= '0;
        end else begin
            case (m_phase)
                0: if (start && !annul) begin
                    m_exp       <= ref_div(a, b, sgn);
                    m_abortable <= (b != 32'd0);
                    m_wait      <= ref_lat(a, b, sgn);
                    if (ref_lat(a, b, sgn) == 0) begin
                        m_phase  <= 2;
                        m_ready  <= 1'b1;
                        m_result <= ref_div(a, b, sgn);
                    end else begin
                        m_phase <= 1;
                    end
                end
                1: if (annul && m_abortable) begin
                    m_phase <= 0;
                end else if (m_wait == 1) begin
                    m_phase  <= 2;
                    m_ready  <= 1'b1;
                    m_result <= m_exp;
                end else begin
                    m_wait <= m_wait - 1;
                end
                default: if (!start) begin
                    m_phase  <= 0;
                    m_ready  <= 1'b0;
                    m_result <= '0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("model_ready", 64'(ready), 64'(m_ready));
            check("model_result", result, m_result);
        end
    end

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input int hold, input int exp_lat, input logic [63:0] lit,
                         input bit scramble);
        int lat;
        bit ok;
        @(negedge clk);
        a = x;
        b = y;
        sgn = s;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (scramble) begin
                a = $urandom;
                b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
                sgn = 1'($urandom_range(0, 1));
            end
            if (ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("ready_timeout", 64'(ok), 64'd1);
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", result, lit);
        repeat (hold) @(posedge clk);
        #1;
        check("result_held", result, lit);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("ready_drop", 64'(ready), 64'd0);
        check("result_clear", result, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y;
        logic        s;
        int          kind;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-computed results.
        do_op(32'd100, 32'd7, 1'b0, 2, 33, {32'h0000_0002, 32'h0000_000E}, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1, 33, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
        do_op(32'h1234_5678, 32'd0, 1'b0, 1, 1, 64'd0, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 33, {32'h0, 32'h8000_0000}, 1'b0);
`ifdef DIV_EARLY_OUT_EN
        do_op(32'd5, 32'd9, 1'b0, 1, 0, {32'd5, 32'd0}, 1'b0);
`else
        do_op(32'd5, 32'd9, 1'b0, 1, 33, {32'd5, 32'd0}, 1'b0);
`endif

        // Annul at iteration 10: no ready, then a fresh divide.
        @(negedge clk);
        a = 32'd1000;
        b = 32'd3;
        sgn = 1'b0;
        start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("annul_no_ready", 64'(ready), 64'd0);
        end
        do_op(32'd9, 32'd3, 1'b0, 0, 33, {32'd0, 32'd3}, 1'b0);

        // Reset during iteration 20.
        @(negedge clk);
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midop_reset_ready", 64'(ready), 64'd0);
        check("midop_reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0, 33, {32'h0000_000F, 32'h0FFF_FFFF}, 1'b0);

        // Randomized operands, signedness and hold times.
        for (int n = 0; n < 150; n++) begin
            s = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 7);
            x = $urandom;
            y = $urandom;
            case (kind)
                0: y = 32'd0;
                1: begin
                    x = 32'h8000_0000;
                    y = 32'hFFFF_FFFF;
                end
                2: begin
                    x = $urandom_range(0, 15);
                    y = $urandom_range(0, 15);
                end
                3: y = $urandom_range(1, 255) * (s && $urandom_range(0, 1) == 1 ? -1 : 1);
                default: ;
            endcase
            do_op(x, y, s, $urandom_range(0, 3), ref_lat(x, y, s), ref_div(x, y, s), 1'b1);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
